// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Turns the UART receiver byte stream into command frames of the form
// SOF, CMD, LEN, PAYLOAD[LEN], CSUM. One payload is buffered, length and
// XOR checksum are verified, an inter-byte timeout aborts stalled frames,
// and a completed frame is offered on a valid/ready handshake.
// Optional build macro: UART_FRAME_ERR_CNT_EN adds saturating 8-bit error
// counters (err_cnt_*) with a synchronous clear input err_cnt_clr.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SOF_BYTE     = 8'hAA,
  parameter int         MAX_LEN      = 16,
  parameter int         ADDR_W       = 4,
  parameter int         TIMEOUT_CLKS = 104170
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [7:0]        frm_cmd,
  output logic [7:0]        frm_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              err_csum,
  output logic              err_len,
  output logic              err_timeout,
`ifdef UART_FRAME_ERR_CNT_EN
  input  logic              err_cnt_clr,
  output logic [7:0]        err_cnt_csum,
  output logic [7:0]        err_cnt_len,
  output logic [7:0]        err_cnt_timeout,
  output logic [7:0]        err_cnt_overrun,
`endif
  output logic              err_overrun
);

  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam int               TMO_W     = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TMO_W-1:0] TMO_TERM  = TMO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [7:0]       csum_r, csum_s;
  logic [7:0]       idx_r, idx_s;
  logic [TMO_W-1:0] tmo_r, tmo_s;
  logic [7:0]       cmd_s, len_s;
  logic             valid_s;
  logic             wr_en_s;
  logic             tmo_term_s;
  logic             err_csum_s, err_len_s, err_timeout_s, err_overrun_s;
  logic [7:0]       pay_mem_r [2**ADDR_W];

  assign tmo_term_s = (tmo_r == TMO_TERM);

  // busy is decoded straight from the state register
  assign busy = (state_r != ST_IDLE);

  // Next-state, datapath updates and error pulse generation
  always_comb begin
    state_s       = state_r;
    csum_s        = csum_r;
    idx_s         = idx_r;
    tmo_s         = tmo_r;
    cmd_s         = frm_cmd;
    len_s         = frm_len;
    valid_s       = frm_valid;
    wr_en_s       = 1'b0;
    err_csum_s    = 1'b0;
    err_len_s     = 1'b0;
    err_timeout_s = 1'b0;
    err_overrun_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tmo_s = {TMO_W{1'b0}};
        if (rx_valid && (rx_data == SOF_BYTE)) begin
          state_s = ST_CMD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (rx_valid) begin
          cmd_s   = rx_data;
          csum_s  = rx_data;
          tmo_s   = {TMO_W{1'b0}};
          state_s = ST_LEN;
        end else if (tmo_term_s) begin
          err_timeout_s = 1'b1;
          tmo_s         = {TMO_W{1'b0}};
          state_s       = ST_IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          tmo_s = {TMO_W{1'b0}};
          if (rx_data > MAX_LEN_B) begin
            err_len_s = 1'b1;
            state_s   = ST_IDLE;
          end else begin
            len_s  = rx_data;
            csum_s = csum_r ^ rx_data;
            idx_s  = 8'd0;
            if (rx_data != 8'd0) begin
              state_s = ST_PAYLOAD;
            end else begin
              state_s = ST_CSUM;
            end
          end
        end else if (tmo_term_s) begin
          err_timeout_s = 1'b1;
          tmo_s         = {TMO_W{1'b0}};
          state_s       = ST_IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          wr_en_s = 1'b1;
          csum_s  = csum_r ^ rx_data;
          idx_s   = idx_r + 8'd1;
          tmo_s   = {TMO_W{1'b0}};
          if (idx_r == (frm_len - 8'd1)) begin
            state_s = ST_CSUM;
          end else begin
            state_s = ST_PAYLOAD;
          end
        end else if (tmo_term_s) begin
          err_timeout_s = 1'b1;
          tmo_s         = {TMO_W{1'b0}};
          state_s       = ST_IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          tmo_s = {TMO_W{1'b0}};
          if (rx_data == csum_r) begin
            valid_s = 1'b1;
            state_s = ST_HOLD;
          end else begin
            err_csum_s = 1'b1;
            state_s    = ST_IDLE;
          end
        end else if (tmo_term_s) begin
          err_timeout_s = 1'b1;
          tmo_s         = {TMO_W{1'b0}};
          state_s       = ST_IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      ST_HOLD: begin
        tmo_s = {TMO_W{1'b0}};
        // A byte arriving while a frame is held is always dropped
        if (rx_valid) begin
          err_overrun_s = 1'b1;
        end else begin
          err_overrun_s = 1'b0;
        end
        if (frm_ready) begin
          valid_s = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        valid_s = 1'b0;
        tmo_s   = {TMO_W{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control state, frame header and registered error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      csum_r      <= 8'd0;
      idx_r       <= 8'd0;
      tmo_r       <= {TMO_W{1'b0}};
      frm_cmd     <= 8'd0;
      frm_len     <= 8'd0;
      frm_valid   <= 1'b0;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_r     <= state_s;
      csum_r      <= csum_s;
      idx_r       <= idx_s;
      tmo_r       <= tmo_s;
      frm_cmd     <= cmd_s;
      frm_len     <= len_s;
      frm_valid   <= valid_s;
      err_csum    <= err_csum_s;
      err_len     <= err_len_s;
      err_timeout <= err_timeout_s;
      err_overrun <= err_overrun_s;
    end
  end

  // Payload buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      pay_mem_r[idx_r[ADDR_W-1:0]] <= rx_data;
    end
  end

  // Registered payload read port, one cycle latency
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 8'd0;
    end else begin
      rd_data <= pay_mem_r[rd_addr];
    end
  end

`ifdef UART_FRAME_ERR_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
    if (en && (v != 8'hFF)) begin
      return v + 8'd1;
    end else begin
      return v;
    end
  endfunction

  // Saturating error counters; clear has priority over a pending increment
  always_ff @(posedge clk) begin
    if (rst || err_cnt_clr) begin
      err_cnt_csum    <= 8'd0;
      err_cnt_len     <= 8'd0;
      err_cnt_timeout <= 8'd0;
      err_cnt_overrun <= 8'd0;
    end else begin
      err_cnt_csum    <= sat_inc8(err_cnt_csum, err_csum);
      err_cnt_len     <= sat_inc8(err_cnt_len, err_len);
      err_cnt_timeout <= sat_inc8(err_cnt_timeout, err_timeout);
      err_cnt_overrun <= sat_inc8(err_cnt_overrun, err_overrun);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: a frame-level reference model (byte queue
// per frame, silence counter, held-frame image) predicts every output each
// cycle; directed frames pin the model with literal expectations, then
// randomized frames with random gaps, lengths, checksums and handshakes.
module tb_uart_rx_frame_ctrl;
  localparam int TMO  = 50;
  localparam int MAXL = 16;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst, rx_valid, frm_ready;
  logic [7:0]    rx_data;
  logic [AW-1:0] rd_addr;
  logic          frm_valid, busy, err_csum, err_len, err_timeout, err_overrun;
  logic [7:0]    frm_cmd, frm_len, rd_data;
`ifdef UART_FRAME_ERR_CNT_EN
  logic          err_cnt_clr;
  logic [7:0]    err_cnt_csum, err_cnt_len, err_cnt_timeout, err_cnt_overrun;
`endif

  uart_rx_frame_ctrl #(.SOF_BYTE(8'hAA), .MAX_LEN(MAXL), .ADDR_W(AW), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_cmd(frm_cmd), .frm_len(frm_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .err_csum(err_csum), .err_len(err_len), .err_timeout(err_timeout),
`ifdef UART_FRAME_ERR_CNT_EN
    .err_cnt_clr(err_cnt_clr), .err_cnt_csum(err_cnt_csum), .err_cnt_len(err_cnt_len),
    .err_cnt_timeout(err_cnt_timeout), .err_cnt_overrun(err_cnt_overrun),
`endif
    .err_overrun(err_overrun));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rand_mode = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  bit         m_in, m_held;
  int         m_sil;
  logic [7:0] m_cmd, m_len;
  logic [7:0] m_mem[1<<AW];
  bit         m_known[1<<AW];
  logic       e_valid, e_busy, e_csum, e_len, e_tmo, e_ovr;
  logic [7:0] e_rd;
  bit         e_rd_known;
`ifdef UART_FRAME_ERR_CNT_EN
  logic [7:0] c_csum, c_len, c_tmo, c_ovr;
`endif

  // Predict the outputs that appear after each rising edge
  always @(posedge clk) begin : model
    logic [7:0] x;
    int n;
`ifdef UART_FRAME_ERR_CNT_EN
    if (rst || err_cnt_clr) begin
      c_csum = 8'd0; c_len = 8'd0; c_tmo = 8'd0; c_ovr = 8'd0;
    end else begin
      if (e_csum && c_csum != 8'hFF) c_csum = c_csum + 8'd1;
      if (e_len  && c_len  != 8'hFF) c_len  = c_len  + 8'd1;
      if (e_tmo  && c_tmo  != 8'hFF) c_tmo  = c_tmo  + 8'd1;
      if (e_ovr  && c_ovr  != 8'hFF) c_ovr  = c_ovr  + 8'd1;
    end
`endif
    e_csum = 1'b0; e_len = 1'b0; e_tmo = 1'b0; e_ovr = 1'b0;
    if (rst) begin
      m_in = 1'b0; m_held = 1'b0; m_sil = 0; m_q.delete();
      m_cmd = 8'd0; m_len = 8'd0; e_rd = 8'd0; e_rd_known = 1'b1;
    end else begin
      e_rd = m_mem[rd_addr];
      e_rd_known = m_known[rd_addr];
      if (m_held) begin
        if (rx_valid) e_ovr = 1'b1;
        if (frm_ready) m_held = 1'b0;
      end else if (m_in) begin
        if (rx_valid) begin
          m_sil = 0;
          m_q.push_back(rx_data);
          n = m_q.size();
          if (n == 1) begin
            m_cmd = rx_data;
          end else if (n == 2) begin
            if (int'(rx_data) > MAXL) begin
              e_len = 1'b1; m_in = 1'b0;
            end else begin
              m_len = rx_data;
            end
          end else if (n <= 2 + int'(m_len)) begin
            m_mem[n-3] = rx_data; m_known[n-3] = 1'b1;
          end else begin
            x = 8'd0;
            for (int i = 0; i < n - 1; i++) x = x ^ m_q[i];
            if (x == rx_data) m_held = 1'b1;
            else e_csum = 1'b1;
            m_in = 1'b0;
          end
        end else begin
          m_sil++;
          if (m_sil == TMO) begin
            e_tmo = 1'b1; m_in = 1'b0;
          end
        end
      end else if (rx_valid && rx_data == 8'hAA) begin
        m_in = 1'b1; m_sil = 0; m_q.delete();
      end
    end
    e_busy  = m_in || m_held;
    e_valid = m_held;
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("frm_valid", frm_valid, e_valid);
      chk1("busy", busy, e_busy);
      chk8("frm_cmd", frm_cmd, m_cmd);
      chk8("frm_len", frm_len, m_len);
      chk1("err_csum", err_csum, e_csum);
      chk1("err_len", err_len, e_len);
      chk1("err_timeout", err_timeout, e_tmo);
      chk1("err_overrun", err_overrun, e_ovr);
      if (e_rd_known) chk8("rd_data", rd_data, e_rd);
`ifdef UART_FRAME_ERR_CNT_EN
      chk8("err_cnt_csum", err_cnt_csum, c_csum);
      chk8("err_cnt_len", err_cnt_len, c_len);
      chk8("err_cnt_timeout", err_cnt_timeout, c_tmo);
      chk8("err_cnt_overrun", err_cnt_overrun, c_ovr);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    if (rand_mode) begin
      rd_addr   = AW'($urandom);
      frm_ready = 1'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic consume();
    frm_ready = 1'b1;
    step();
    frm_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] cmd, len, x;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; frm_ready = 1'b0; rd_addr = '0;
`ifdef UART_FRAME_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk1("reset_valid", frm_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk8("reset_cmd", frm_cmd, 8'h00);
    chk8("reset_rd", rd_data, 8'h00);
    rst = 1'b0;
    step();

    // Test 1: good frame and payload read-back
    send(8'hAA); send(8'h01); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h02);
    chk1("t1_valid", frm_valid, 1'b1);
    chk8("t1_cmd", frm_cmd, 8'h01);
    chk8("t1_len", frm_len, 8'h03);
    rd_addr = 4'd0; step(); chk8("t1_rd0", rd_data, 8'h10);
    rd_addr = 4'd1; step(); chk8("t1_rd1", rd_data, 8'h20);
    rd_addr = 4'd2; step(); chk8("t1_rd2", rd_data, 8'h30);
    consume();
    chk1("t1_consumed", frm_valid, 1'b0);
    chk1("t1_idle", busy, 1'b0);

    // Test 2: bad checksum, then zero-length frame
    send(8'hAA); send(8'h01); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h03);
    chk1("t2_err_csum", err_csum, 1'b1);
    chk1("t2_busy", busy, 1'b0);
    step();
    chk1("t2_pulse_end", err_csum, 1'b0);
    chk1("t2_no_valid", frm_valid, 1'b0);
    send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
    chk1("t2_valid", frm_valid, 1'b1);
    chk8("t2_cmd", frm_cmd, 8'h05);
    chk8("t2_len", frm_len, 8'h00);
    consume();

    // Test 3: length error, trailing bytes ignored, then a good frame
    send(8'hAA); send(8'h07); send(8'h11);
    chk1("t3_err_len", err_len, 1'b1);
    send(8'h55); send(8'h66);
    chk1("t3_ignored", busy, 1'b0);
    send(8'hAA); send(8'h02); send(8'h01); send(8'h7E); send(8'h7D);
    chk1("t3_valid", frm_valid, 1'b1);
    consume();

    // Test 4: timeout latency, and a byte on the terminal cycle wins
    send(8'hAA); send(8'h01);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (err_timeout) begin
        lat = i;
        break;
      end
    end
    chk8("t4_latency", 8'(lat), 8'd50);
    chk1("t4_busy", busy, 1'b0);
    send(8'hAA); send(8'h01);
    idle(TMO - 1);
    send(8'h00);
    chk1("t4_terminal_no_tmo", err_timeout, 1'b0);
    chk1("t4_terminal_busy", busy, 1'b1);
    send(8'h01);
    chk1("t4_valid", frm_valid, 1'b1);
    consume();

    // Test 5: overrun while holding a frame
    send(8'hAA); send(8'h01); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h02);
    send(8'h99);
    chk1("t5_overrun", err_overrun, 1'b1);
    chk1("t5_still_valid", frm_valid, 1'b1);
    chk8("t5_cmd", frm_cmd, 8'h01);
    chk8("t5_len", frm_len, 8'h03);
    rd_addr = 4'd1; step(); chk8("t5_rd1", rd_data, 8'h20);
    consume();
    chk1("t5_consumed", frm_valid, 1'b0);

    // Test 6: reset in the middle of the payload
    send(8'hAA); send(8'h01); send(8'h03); send(8'h10);
    rst = 1'b1; step(); rst = 1'b0;
    chk1("t6_busy", busy, 1'b0);
    chk8("t6_cmd", frm_cmd, 8'h00);
    chk8("t6_len", frm_len, 8'h00);
    chk8("t6_rd", rd_data, 8'h00);
    send(8'h20); send(8'h30); send(8'h02);
    chk1("t6_ignored", busy, 1'b0);
    chk1("t6_no_valid", frm_valid, 1'b0);

    // Randomized frames: gaps, bad lengths, bad checksums, stalls, handshakes
    rand_mode = 1'b1;
    for (int f = 0; f < 60; f++) begin
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) send(8'($urandom));
      send(8'hAA);
      cmd = 8'($urandom);
      len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(17, 255)) : 8'($urandom_range(0, 16));
      x = cmd ^ len;
      send(cmd); idle($urandom_range(0, 2));
      send(len);
      if (int'(len) <= MAXL) begin
        for (int i = 0; i < int'(len); i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          x = x ^ b;
          idle($urandom_range(0, 2));
          if ($urandom_range(0, 29) == 0) idle(TMO + 5);
          send(b);
        end
        idle($urandom_range(0, 2));
        send(($urandom_range(0, 3) == 0) ? (x ^ 8'h5A) : x);
      end
    end
    rand_mode = 1'b0;
    frm_ready = 1'b1;
    idle(TMO + 10);
    frm_ready = 1'b0;

`ifdef UART_FRAME_ERR_CNT_EN
    err_cnt_clr = 1'b1; step(); err_cnt_clr = 1'b0;
    for (int f = 0; f < 300; f++) begin
      send(8'hAA); send(8'h01); send(8'h00); send(8'h00);
    end
    step();
    chk8("cnt_csum_sat", err_cnt_csum, 8'hFF);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
